// File: rtl/fft_lcd_pkg.sv
`default_nettype none
// ============================================================================
// fft_lcd_pkg : shared state encoding, default sizes and sample conversion
// Revision 1.0
// ============================================================================
package fft_lcd_pkg;

    localparam int N_POINTS_DEF = 256;
    localparam int AW_DEF       = 8;
    localparam int DW_IN_DEF    = 8;
    localparam int FFT_DW_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        FEED    = 3'd2,
        RESULT  = 3'd3,
        DONE    = 3'd4
    } fft_state_e;

    // Offset-binary ADC code to MSB-aligned two's complement (0x80 -> 0x0000).
    function automatic logic [FFT_DW_DEF-1:0] offset_to_signed(input logic [DW_IN_DEF-1:0] d);
        return {~d[DW_IN_DEF-1], d[DW_IN_DEF-2:0], {(FFT_DW_DEF-DW_IN_DEF){1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_buffer_ram.sv
`default_nettype none
// ============================================================================
// sample_buffer_ram : simple dual-port frame buffer, one write, one sync read
// Revision 1.0
// ============================================================================
module sample_buffer_ram
    import fft_lcd_pkg::*;
#(
    parameter int DEPTH = N_POINTS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = FFT_DW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fft_frame_capture.sv
`default_nettype none
// ============================================================================
// fft_frame_capture : captures one ADC frame, streams it to the FFT core and
//                     writes approximate bin magnitudes to the spectrum RAM.
// Revision 1.0
// ============================================================================
module fft_frame_capture
    import fft_lcd_pkg::*;
#(
    parameter int N_POINTS = N_POINTS_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW_IN    = DW_IN_DEF,
    parameter int FFT_DW   = FFT_DW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fft_start,
    input  logic [DW_IN-1:0]  ad_data,
    input  logic              ad_en,
    output logic [FFT_DW-1:0] s_fft_data,
    output logic              s_fft_valid,
    input  logic              s_fft_ready,
    output logic              s_fft_last,
    input  logic [FFT_DW-1:0] m_fft_re,
    input  logic [FFT_DW-1:0] m_fft_im,
    input  logic              m_fft_valid,
    input  logic              m_fft_last,
    output logic              m_fft_ready,
    output logic [AW-1:0]     mag_waddr,
    output logic [FFT_DW-1:0] mag_wdata,
    output logic              mag_we,
    output logic              fft_over,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [AW-1:0]     c_last_idx = AW'(N_POINTS - 1);
    localparam logic [AW-1:0]     c_idx_one  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [FFT_DW-1:0] c_mag_one  = {{(FFT_DW-1){1'b0}}, 1'b1};

    fft_state_e        state_q, state_d;
    logic [AW-1:0]     wcnt_q, wcnt_d;
    logic [AW-1:0]     rcnt_q, rcnt_d;
    logic [AW-1:0]     bcnt_q, bcnt_d;
    logic              sat_q, sat_d;
    logic              last_seen_q, last_seen_d;
    logic              frame_err_q, frame_err_d;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q, s1_last_d;
    logic [FFT_DW-1:0] s1_a_q, s1_a_d;
    logic [FFT_DW-1:0] s1_b_q, s1_b_d;
    logic [AW-1:0]     s1_idx_q, s1_idx_d;
    logic              mag_we_q, mag_we_d;
    logic              s2_last_q, s2_last_d;
    logic [AW-1:0]     mag_waddr_q, mag_waddr_d;
    logic [FFT_DW-1:0] mag_wdata_q, mag_wdata_d;

    logic [FFT_DW-1:0] w_sample_s;
    logic [FFT_DW-1:0] w_ram_rdata;
    logic [AW-1:0]     w_ram_raddr;
    logic              w_ram_we;
    logic              w_feed_acc;
    logic              w_bin_acc;
    logic [FFT_DW-1:0] w_max;
    logic [FFT_DW-1:0] w_min;

    // |-2^(FFT_DW-1)| wraps to 2^(FFT_DW-1), which is the correct unsigned result.
    function automatic logic [FFT_DW-1:0] abs_u(input logic [FFT_DW-1:0] v);
        return v[FFT_DW-1] ? ((~v) + c_mag_one) : v;
    endfunction

    generate
        if (DW_IN == DW_IN_DEF && FFT_DW == FFT_DW_DEF) begin : g_conv_pkg
            assign w_sample_s = offset_to_signed(ad_data);
        end else begin : g_conv_generic
            assign w_sample_s = {~ad_data[DW_IN-1], ad_data[DW_IN-2:0], {(FFT_DW-DW_IN){1'b0}}};
        end
    endgenerate

    assign s_fft_valid = (state_q == FEED);
    assign s_fft_last  = s_fft_valid && (rcnt_q == c_last_idx);
    assign s_fft_data  = s_fft_valid ? w_ram_rdata : '0;
    assign m_fft_ready = (state_q == RESULT) && !last_seen_q;
    assign w_feed_acc  = s_fft_valid && s_fft_ready;
    assign w_bin_acc   = m_fft_valid && m_fft_ready;
    assign w_ram_we    = (state_q == CAPTURE) && ad_en;

    // The RAM output register is the stream's data register: on a stall the
    // same address is re-read, on acceptance the next one is prefetched.
    assign w_ram_raddr = (w_feed_acc && !s_fft_last) ? (rcnt_q + c_idx_one) : rcnt_q;

    sample_buffer_ram #(
        .DEPTH (N_POINTS),
        .AW    (AW),
        .DW    (FFT_DW)
    ) u_buf (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (wcnt_q),
        .wdata (w_sample_s),
        .raddr (w_ram_raddr),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        bcnt_d      = bcnt_q;
        sat_d       = sat_q;
        last_seen_d = last_seen_q;
        frame_err_d = frame_err_q;
        case (state_q)
            IDLE: begin
                if (fft_start) begin
                    state_d     = CAPTURE;
                    wcnt_d      = '0;
                    rcnt_d      = '0;
                    frame_err_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (ad_en) begin
                    wcnt_d = wcnt_q + c_idx_one;
                    if (wcnt_q == c_last_idx) begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (w_feed_acc) begin
                    if (s_fft_last) begin
                        state_d     = RESULT;
                        bcnt_d      = '0;
                        sat_d       = 1'b0;
                        last_seen_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + c_idx_one;
                    end
                end
            end
            RESULT: begin
                if (w_bin_acc) begin
                    if (m_fft_last) begin
                        last_seen_d = 1'b1;
                        if (bcnt_q != c_last_idx || sat_q) begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        // Surplus bins keep overwriting the top address.
                        if (sat_q) begin
                            frame_err_d = 1'b1;
                        end
                        if (bcnt_q == c_last_idx) begin
                            sat_d = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + c_idx_one;
                        end
                    end
                end
                if (s2_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s1_valid_d  = w_bin_acc;
        s1_last_d   = w_bin_acc && m_fft_last;
        s1_a_d      = w_bin_acc ? abs_u(m_fft_re) : s1_a_q;
        s1_b_d      = w_bin_acc ? abs_u(m_fft_im) : s1_b_q;
        s1_idx_d    = w_bin_acc ? bcnt_q : s1_idx_q;
        w_max       = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
        w_min       = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
        mag_we_d    = s1_valid_q;
        s2_last_d   = s1_last_q;
        mag_waddr_d = s1_valid_q ? s1_idx_q : mag_waddr_q;
        mag_wdata_d = s1_valid_q ? (w_max + (w_min >> 1)) : mag_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            bcnt_q      <= '0;
            sat_q       <= 1'b0;
            last_seen_q <= 1'b0;
            frame_err_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_idx_q    <= '0;
            mag_we_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            mag_waddr_q <= '0;
            mag_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            bcnt_q      <= bcnt_d;
            sat_q       <= sat_d;
            last_seen_q <= last_seen_d;
            frame_err_q <= frame_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_idx_q    <= s1_idx_d;
            mag_we_q    <= mag_we_d;
            s2_last_q   <= s2_last_d;
            mag_waddr_q <= mag_waddr_d;
            mag_wdata_q <= mag_wdata_d;
        end
    end

    assign mag_we    = mag_we_q;
    assign mag_waddr = mag_waddr_q;
    assign mag_wdata = mag_wdata_q;
    assign fft_over  = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_capture.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_capture : randomized frame capture / feed / magnitude checks
// Revision 1.0
// ============================================================================
module tb_fft_frame_capture;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fft_start = 1'b0;
    logic [7:0]  ad_data = '0;
    logic        ad_en = 1'b0;
    logic [15:0] s_fft_data;
    logic        s_fft_valid;
    logic        s_fft_ready = 1'b0;
    logic        s_fft_last;
    logic [15:0] m_fft_re = '0;
    logic [15:0] m_fft_im = '0;
    logic        m_fft_valid = 1'b0;
    logic        m_fft_last = 1'b0;
    logic        m_fft_ready;
    logic [7:0]  mag_waddr;
    logic [15:0] mag_wdata;
    logic        mag_we;
    logic        fft_over;
    logic        busy;
    logic        frame_err;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [15:0] exp_samp [N];

    typedef struct {
        int          due;
        logic [7:0]  addr;
        logic [15:0] mag;
    } wr_t;

    fft_frame_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fft_start   (fft_start),
        .ad_data     (ad_data),
        .ad_en       (ad_en),
        .s_fft_data  (s_fft_data),
        .s_fft_valid (s_fft_valid),
        .s_fft_ready (s_fft_ready),
        .s_fft_last  (s_fft_last),
        .m_fft_re    (m_fft_re),
        .m_fft_im    (m_fft_im),
        .m_fft_valid (m_fft_valid),
        .m_fft_last  (m_fft_last),
        .m_fft_ready (m_fft_ready),
        .mag_waddr   (mag_waddr),
        .mag_wdata   (mag_wdata),
        .mag_we      (mag_we),
        .fft_over    (fft_over),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Reference: ADC code minus mid-scale, scaled to the top of 16 bits.
    function automatic logic [15:0] ref_conv(input logic [7:0] d);
        int v;
        v = (int'(d) - 128) * 256;
        return 16'(v);
    endfunction

    function automatic logic [15:0] ref_mag(input logic [15:0] re, input logic [15:0] im);
        int r, i, a, b, hi, lo;
        r  = $signed(re);
        i  = $signed(im);
        a  = (r < 0) ? -r : r;
        b  = (i < 0) ? -i : i;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        return 16'(hi + lo / 2);
    endfunction

    // Starts a frame and delivers N samples; returns at the first FEED cycle.
    task automatic do_capture(input bit ramp, input int en_pct);
        int wc;
        wc = 0;
        @(negedge clk);
        fft_start   = 1'b1;
        ad_en       = 1'b1;
        ad_data     = 8'h55;
        m_fft_valid = 1'b1;
        m_fft_last  = 1'b0;
        @(negedge clk);
        fft_start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL start_ack: busy=%0b frame_err=%0b, required busy=1 frame_err=0", busy, frame_err);
        end
        while (wc < N) begin
            vectors++;
            if (s_fft_valid !== 1'b0 || busy !== 1'b1 || mag_we !== 1'b0) begin
                errors++;
                $display("FAIL capture_idle_out: valid=%0b busy=%0b we=%0b, required 0/1/0", s_fft_valid, busy, mag_we);
            end
            ad_en    = ($urandom_range(99) < en_pct);
            ad_data  = ramp ? 8'(wc) : 8'($urandom);
            m_fft_re = 16'($urandom);
            if (ad_en) begin
                exp_samp[wc] = ref_conv(ad_data);
                wc++;
            end
            @(negedge clk);
        end
        ad_en = 1'b0;
    endtask

    task automatic do_feed(input int ready_pct, input int stop_after);
        int k, guard;
        k = 0;
        guard = 0;
        while (k < stop_after) begin
            vectors++;
            if (s_fft_valid !== 1'b1 || s_fft_data !== exp_samp[k] ||
                s_fft_last !== (k == N - 1) || mag_we !== 1'b0) begin
                errors++;
                $display("FAIL feed_sample %0d: valid=%0b data=%h last=%0b we=%0b, required valid=1 data=%h last=%0b we=0",
                         k, s_fft_valid, s_fft_data, s_fft_last, mag_we, exp_samp[k], (k == N - 1));
            end
            s_fft_ready = ($urandom_range(99) < ready_pct);
            if (s_fft_ready) k++;
            guard++;
            if (guard > 20 * N) begin
                errors++;
                $display("FAIL feed_timeout: %0d samples accepted, required %0d", k, stop_after);
                break;
            end
            @(negedge clk);
        end
        s_fft_ready = 1'b0;
        m_fft_valid = 1'b0;
    endtask

    // Supplies bins until last_at (index), checks every write and the fft_over pulse.
    task automatic do_result(input int last_at, input bit special, input int poke_at);
        wr_t q[$];
        wr_t w;
        int  bin, last_cyc, guard;
        bit  last_done, seen_over, exp_err;
        bin = 0;
        last_cyc = 0;
        last_done = 1'b0;
        seen_over = 1'b0;
        exp_err = (last_at != N - 1);
        vectors++;
        if (s_fft_valid !== 1'b0 || s_fft_last !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: valid=%0b last=%0b after final sample, required 0/0", s_fft_valid, s_fft_last);
        end
        for (guard = 0; guard < 4 * N; guard++) begin
            vectors++;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (mag_we !== 1'b1 || mag_waddr !== q[0].addr || mag_wdata !== q[0].mag) begin
                    errors++;
                    $display("FAIL mag_write: we=%0b addr=%0d data=%0d, required we=1 addr=%0d data=%0d",
                             mag_we, mag_waddr, mag_wdata, q[0].addr, q[0].mag);
                end
                q.delete(0);
            end else if (mag_we !== 1'b0) begin
                errors++;
                $display("FAIL mag_spurious: we=%0b addr=%0d, required we=0", mag_we, mag_waddr);
            end
            if (!last_done) begin
                vectors++;
                if (m_fft_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL result_ready: m_fft_ready=%0b, required 1", m_fft_ready);
                end
            end
            if (fft_over === 1'b1) begin
                seen_over = 1'b1;
                vectors++;
                if (!last_done || cyc != last_cyc + 3 || q.size() != 0) begin
                    errors++;
                    $display("FAIL over_latency: at %0d cycles after last bin with %0d writes pending, required 3 and 0",
                             cyc - last_cyc, q.size());
                end
                break;
            end
            fft_start = (guard == poke_at);
            if (!last_done) begin
                m_fft_valid = ($urandom_range(99) < 70);
                m_fft_re = 16'($urandom);
                m_fft_im = 16'($urandom);
                if (special) begin
                    case (bin)
                        0: begin m_fft_re = 16'd3;     m_fft_im = 16'hFFFC; end
                        1: begin m_fft_re = 16'h8000;  m_fft_im = 16'h0000; end
                        2: begin m_fft_re = 16'h8000;  m_fft_im = 16'h8000; end
                        3: begin m_fft_re = 16'h7FFF;  m_fft_im = 16'h8001; end
                        default: ;
                    endcase
                end
                m_fft_last = (bin == last_at);
                if (m_fft_valid && m_fft_ready) begin
                    w.due  = cyc + 2;
                    w.addr = 8'((bin > N - 1) ? N - 1 : bin);
                    w.mag  = ref_mag(m_fft_re, m_fft_im);
                    q.push_back(w);
                    if (bin == last_at) begin
                        last_done = 1'b1;
                        last_cyc  = cyc;
                    end
                    bin++;
                end
            end else begin
                m_fft_valid = 1'b0;
                m_fft_last  = 1'b0;
            end
            @(negedge clk);
        end
        fft_start   = 1'b0;
        m_fft_valid = 1'b0;
        m_fft_last  = 1'b0;
        vectors++;
        if (!seen_over || frame_err !== exp_err) begin
            errors++;
            $display("FAIL frame_end: fft_over_seen=%0b frame_err=%0b, required 1 and %0b", seen_over, frame_err, exp_err);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (fft_over !== 1'b0 || busy !== 1'b0 || m_fft_ready !== 1'b0 || frame_err !== exp_err) begin
                errors++;
                $display("FAIL post_frame_idle: over=%0b busy=%0b ready=%0b err=%0b, required 0/0/0/%0b",
                         fft_over, busy, m_fft_ready, frame_err, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, s_fft_valid, s_fft_last, m_fft_ready, mag_we, fft_over, frame_err} !== 7'b0 ||
            s_fft_data !== 16'h0 || mag_wdata !== 16'h0 || mag_waddr !== 8'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b valid=%0b ready=%0b we=%0b over=%0b err=%0b data=%h, required all 0",
                     busy, s_fft_valid, m_fft_ready, mag_we, fft_over, frame_err, s_fft_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_ramp();
        do_capture(1'b1, 100);
        do_feed(100, N);
        do_result(N - 1, 1'b0, -1);
    endtask

    task automatic test_stall();
        do_capture(1'b0, 60);
        do_feed(50, N);
        do_result(N - 1, 1'b0, -1);
    endtask

    task automatic test_magnitude();
        do_capture(1'b0, 100);
        do_feed(100, N);
        do_result(N - 1, 1'b1, -1);
    endtask

    task automatic test_early_last();
        do_capture(1'b0, 100);
        do_feed(80, N);
        do_result(100, 1'b0, -1);
    endtask

    task automatic test_overrun();
        do_capture(1'b0, 100);
        do_feed(100, N);
        do_result(N + 3, 1'b0, -1);
    endtask

    task automatic test_abort_in_feed();
        do_capture(1'b0, 100);
        do_feed(100, 40);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, s_fft_valid, s_fft_last, m_fft_ready, mag_we, fft_over, frame_err} !== 7'b0 ||
            s_fft_data !== 16'h0) begin
            errors++;
            $display("FAIL abort_async: busy=%0b valid=%0b last=%0b data=%h over=%0b, required all 0",
                     busy, s_fft_valid, s_fft_last, s_fft_data, fft_over);
        end
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (fft_over !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold: over=%0b busy=%0b, required 0/0", fft_over, busy);
            end
        end
        rst_n = 1'b1;
        test_ramp();
    endtask

    task automatic test_start_ignored();
        do_capture(1'b0, 100);
        do_feed(100, N);
        do_result(N - 1, 1'b0, 10);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            do_capture(1'b0, 90);
            do_feed(75, N);
            do_result(N - 1, 1'b1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_magnitude();
        test_early_last();
        test_overrun();
        test_abort_in_feed();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
